// File: rtl/led_phase_sequencer.sv
// Tri-colour status LED scheduler: debounces two active-low buttons, runs a
// STOP/RUN/PAUSE machine and cycles RED -> GREEN -> BLUE with programmable durations.
module led_phase_sequencer #(
    parameter int unsigned RED_CYCLES      = 30_000_000,
    parameter int unsigned GREEN_CYCLES    = 30_000_000,
    parameter int unsigned BLUE_CYCLES     = 30_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 270_000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_0,
    input  logic       button_1,
    output logic [2:0] led,
    output logic [1:0] phase,
    output logic       running,
    output logic       phase_tick
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [1:0] PH_RED   = 2'd0;
    localparam logic [1:0] PH_GREEN = 2'd1;
    localparam logic [1:0] PH_BLUE  = 2'd2;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LIM    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLUE_LAST  = CNT_W'(BLUE_CYCLES - 1);

    // Bit 0 is the STOP button, bit 1 is START/PAUSE.
    logic [1:0]       w_btn;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0]       r_deb_q;
    logic [CNT_W-1:0] r_deb_cnt [2];
    logic [CNT_W-1:0] w_deb_inc [2];
    logic [1:0]       w_press;
    logic             w_stop;
    logic             w_start;

    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_d;
    logic [1:0]       w_phase_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_d;
    logic [CNT_W-1:0] w_dur_last;
    logic             r_tick;
    logic             w_tick_d;

    assign w_btn = {button_1, button_0};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_deb_inc[i] = r_deb_cnt[i] + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1      <= 2'b11;
            r_sync2      <= 2'b11;
            r_deb        <= 2'b11;
            r_deb_q      <= 2'b11;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (w_deb_inc[i] == DEB_LIM) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= w_deb_inc[i];
                end
            end
        end
    end

    // Only the falling (press) edge of the debounced level is an event.
    assign w_press = r_deb_q & ~r_deb;
    assign w_stop  = w_press[0];
    assign w_start = w_press[1];

    always_comb begin
        case (r_phase)
            PH_GREEN: w_dur_last = GREEN_LAST;
            PH_BLUE:  w_dur_last = BLUE_LAST;
            default:  w_dur_last = RED_LAST;
        endcase
    end

    always_comb begin
        case (r_phase)
            PH_RED:   w_phase_next = PH_GREEN;
            PH_GREEN: w_phase_next = PH_BLUE;
            default:  w_phase_next = PH_RED;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_phase_d = r_phase;
        w_timer_d = r_timer;
        w_tick_d  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_stop) begin
                    w_state_d = ST_STOP;
                    w_phase_d = PH_RED;
                    w_timer_d = '0;
                end else if (w_start) begin
                    w_state_d = ST_PAUSE;
                end else if (r_timer == w_dur_last) begin
                    w_timer_d = '0;
                    w_phase_d = w_phase_next;
                    w_tick_d  = 1'b1;
                end else begin
                    w_timer_d = r_timer + ONE;
                end
            end
            ST_PAUSE: begin
                if (w_stop) begin
                    w_state_d = ST_STOP;
                    w_phase_d = PH_RED;
                    w_timer_d = '0;
                end else if (w_start) begin
                    w_state_d = ST_RUN;
                end
            end
            default: begin
                // Also recovers the unused state encoding into STOP.
                w_state_d = ST_STOP;
                w_phase_d = PH_RED;
                w_timer_d = '0;
                if (w_start && !w_stop) begin
                    w_state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOP;
            r_phase <= PH_RED;
            r_timer <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_phase <= w_phase_d;
            r_timer <= w_timer_d;
            r_tick  <= w_tick_d;
        end
    end

    always_comb begin
        case (r_phase)
            PH_GREEN: led = 3'b101;
            PH_BLUE:  led = 3'b011;
            default:  led = 3'b110;
        endcase
    end

    assign phase      = r_phase;
    assign running    = (r_state == ST_RUN);
    assign phase_tick = r_tick;

endmodule

// File: tb/tb_led_phase_sequencer.sv
// Bench for led_phase_sequencer: segment table drives buttons, a queue holds
// the expected outputs for each clock, compared shortly after each rising edge.
module tb_led_phase_sequencer;

    localparam logic [2:0] R = 3'b110;
    localparam logic [2:0] G = 3'b101;
    localparam logic [2:0] B = 3'b011;
    localparam logic       H = 1'b1;
    localparam logic       L = 1'b0;

    typedef struct {
        int         grp;
        logic       b0;
        logic       b1;
        int         n;
        logic [2:0] led;
        logic [1:0] ph;
        logic       run;
        logic       tick;
    } seg_t;

    typedef struct {
        logic [6:0] v;
        int         tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       button_0;
    logic       button_1;
    logic [2:0] led;
    logic [1:0] phase;
    logic       running;
    logic       phase_tick;

    seg_t tbl[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    led_phase_sequencer #(
        .RED_CYCLES      (5),
        .GREEN_CYCLES    (3),
        .BLUE_CYCLES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button_0   (button_0),
        .button_1   (button_1),
        .led        (led),
        .phase      (phase),
        .running    (running),
        .phase_tick (phase_tick)
    );

    task automatic check_now(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got led=%b phase=%0d running=%b tick=%b, expected led=%b phase=%0d running=%b tick=%b",
                     name, act[6:4], act[3:2], act[1], act[0], exp[6:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input int g, input logic b0, input logic b1, input int n,
                       input logic [2:0] l, input logic [1:0] p, input logic r, input logic t);
        seg_t s;
        s.grp  = g;
        s.b0   = b0;
        s.b1   = b1;
        s.n    = n;
        s.led  = l;
        s.ph   = p;
        s.run  = r;
        s.tick = t;
        tbl.push_back(s);
    endtask

    // Each step: drive at the falling edge, expect the state after the next rising edge.
    task automatic play(input int g);
        exp_t e;
        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].grp == g) begin
                for (int c = 0; c < tbl[k].n; c++) begin
                    @(negedge clk);
                    button_0 = tbl[k].b0;
                    button_1 = tbl[k].b1;
                    e.v   = {tbl[k].led, tbl[k].ph, tbl[k].run, tbl[k].tick};
                    e.tag = k;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_now($sformatf("seg%0d", e.tag), {led, phase, running, phase_tick}, e.v);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion well before 200000");
        $fatal(1);
    end

    initial begin
        // Group 0: idle, short pulse, run/wrap, pause/resume, simultaneous stop+start.
        add(0, H, H, 20, R, 2'd0, L, L);
        add(0, H, L, 3,  R, 2'd0, L, L);  // 3-cycle glitch is rejected
        add(0, H, H, 10, R, 2'd0, L, L);
        add(0, H, L, 4,  R, 2'd0, L, L);  // exactly-DEBOUNCE pulse is accepted
        add(0, H, H, 2,  R, 2'd0, L, L);
        add(0, H, H, 1,  R, 2'd0, H, L);
        add(0, H, H, 4,  R, 2'd0, H, L);
        add(0, H, H, 1,  G, 2'd1, H, H);
        add(0, H, H, 2,  G, 2'd1, H, L);
        add(0, H, H, 1,  B, 2'd2, H, H);
        add(0, H, H, 1,  B, 2'd2, H, L);
        add(0, H, H, 1,  R, 2'd0, H, H);
        add(0, H, L, 4,  R, 2'd0, H, L);  // pause press lands with GREEN timer=1
        add(0, H, H, 1,  G, 2'd1, H, H);
        add(0, H, H, 1,  G, 2'd1, H, L);
        add(0, H, H, 50, G, 2'd1, L, L);
        add(0, H, L, 4,  G, 2'd1, L, L);
        add(0, H, H, 2,  G, 2'd1, L, L);
        add(0, H, H, 2,  G, 2'd1, H, L);
        add(0, H, H, 1,  B, 2'd2, H, H);
        add(0, H, H, 1,  B, 2'd2, H, L);
        add(0, L, L, 1,  R, 2'd0, H, H);
        add(0, L, L, 3,  R, 2'd0, H, L);
        add(0, H, H, 1,  R, 2'd0, H, L);
        add(0, H, H, 1,  G, 2'd1, H, H);
        add(0, H, H, 11, R, 2'd0, L, L);
        // Group 1: run into BLUE ahead of the asynchronous reset.
        add(1, H, L, 4,  R, 2'd0, L, L);
        add(1, H, H, 2,  R, 2'd0, L, L);
        add(1, H, H, 1,  R, 2'd0, H, L);
        add(1, H, H, 4,  R, 2'd0, H, L);
        add(1, H, H, 1,  G, 2'd1, H, H);
        add(1, H, H, 2,  G, 2'd1, H, L);
        add(1, H, H, 1,  B, 2'd2, H, H);
        // Group 2: quiet after reset release.
        add(2, H, H, 15, R, 2'd0, L, L);

        rst      = 1'b1;
        button_0 = 1'b1;
        button_1 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_now("reset", {led, phase, running, phase_tick}, {R, 2'd0, L, L});
        @(negedge clk);
        rst = 1'b0;

        play(0);
        play(1);

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_now("async_rst", {led, phase, running, phase_tick}, {R, 2'd0, L, L});
        @(posedge clk);
        #2;
        check_now("rst_held", {led, phase, running, phase_tick}, {R, 2'd0, L, L});
        @(negedge clk);
        rst = 1'b0;

        play(2);

        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
